immediate_reader: RTL and testbench

- Fetches 8- or 16-bit immediates and displacements from the instruction-stream FIFO for the decoder.
- Serves the ModR/M decode stage through its immed_start / immed_is_8bit / immed_complete / immediate handshake.
- Shares the FIFO read port with that stage, multiplexed by the core. Each is enabled only while it owns the stream.
- An 8-bit value is sign-extended to 16 bits. A 16-bit value is assembled little-endian.

---
 rtl/immediate_reader_pkg.sv | 12 +
 rtl/immediate_reader.sv | 82 ++++++++
 tb/tb_immediate_reader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/immediate_reader_pkg.sv
// Shared definitions for the immediate/displacement fetch unit.
package immediate_reader_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} immed_state_t;

  localparam int IMMED_MAX_BYTES = 2;

  function automatic logic [15:0] sign_extend8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/immediate_reader.sv
// Pulls a 1- or 2-byte immediate out of the instruction-stream FIFO and hands
// it to the ModR/M decode stage as a 16-bit value.
module immediate_reader
  import immediate_reader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_8bit,
  input  logic        clear,
  output logic        busy,
  output logic        complete,
  output logic [15:0] immediate,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty
);

  immed_state_t state, state_next;
  logic [1:0]   need, req_cnt, got_cnt;
  logic         rd_pending, mode_8bit, start_hold;
  logic [7:0]   lo_byte;
  logic         accept, latch, final_latch;

  // start_hold blocks re-acceptance of a request level still held from the previous op
  always_comb begin
    accept      = (state == IDLE) & start & ~start_hold & ~clear;
    latch       = (state == FETCH) & rd_pending & ~clear;
    final_latch = latch & ((got_cnt + 2'd1) == need);
    fifo_rd_en  = (state == FETCH) & ~fifo_empty & (req_cnt != need) & ~clear;
    complete    = (state == DONE) & ~clear;
    busy        = (state == FETCH) | ((state == IDLE) & start & ~start_hold & reset);

    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = FETCH;
      FETCH:   if (final_latch) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      need       <= '0;
      req_cnt    <= '0;
      got_cnt    <= '0;
      rd_pending <= 1'b0;
      mode_8bit  <= 1'b0;
      start_hold <= 1'b0;
      lo_byte    <= '0;
      immediate  <= '0;
    end else begin
      state      <= state_next;
      start_hold <= start & (start_hold | accept);
      if (clear) begin
        rd_pending <= 1'b0;
        req_cnt    <= '0;
        got_cnt    <= '0;
      end else if (accept) begin
        need       <= is_8bit ? 2'd1 : 2'(IMMED_MAX_BYTES);
        mode_8bit  <= is_8bit;
        req_cnt    <= '0;
        got_cnt    <= '0;
        rd_pending <= 1'b0;
      end else begin
        rd_pending <= fifo_rd_en;
        if (fifo_rd_en) req_cnt <= req_cnt + 2'd1;
        // Bytes arrive low first; the final one is merged straight into the result
        if (latch) begin
          got_cnt <= got_cnt + 2'd1;
          if (got_cnt == 2'd0) lo_byte <= fifo_rd_data;
          if (final_latch)
            immediate <= mode_8bit ? sign_extend8(fifo_rd_data) : {fifo_rd_data, lo_byte};
        end
      end
    end
  end

endmodule

// File: tb/tb_immediate_reader.sv
// Self-checking bench for immediate_reader: table vectors, random ops against a
// timing/value reference model, and hand sequences for clear and reset.
module tb_immediate_reader;

  logic        clk = 1'b0;
  logic        reset, start, is_8bit, clear;
  logic        busy, complete, fifo_rd_en, fifo_empty;
  logic [15:0] immediate;
  logic [7:0]  fifo_rd_data = 8'h00;

  logic [7:0]  fifo_mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_count = 0;
  int          empty_reads = 0;
  logic        flush = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] prev_imm = 16'h0000;

  typedef struct {
    logic        is8;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          d0;
    int          d1;
    logic        hold;
    logic [15:0] exp_imm;
    int          exp_lat;
    int          exp_pops;
  } vec_t;

  vec_t vecs [6];

  immediate_reader dut (
    .clk(clk), .reset(reset), .start(start), .is_8bit(is_8bit), .clear(clear),
    .busy(busy), .complete(complete), .immediate(immediate),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: data appears the cycle after a pop request
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) empty_reads <= empty_reads + 1;
      else begin
        fifo_rd_data <= fifo_mem[rd_ptr % 256];
        rd_ptr       <= rd_ptr + 1;
        pop_count    <= pop_count + 1;
      end
    end
  end

  task automatic pushByte(input logic [7:0] b);
    fifo_mem[wr_ptr % 256] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flushFifo();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference: first byte is read once it is available (earliest cycle 1),
  // second one cycle later at the earliest; result shows two cycles after the last read.
  function automatic int refLatency(input logic is8, input int d0, input int d1);
    int r0, r1;
    r0 = (d0 > 1) ? d0 : 1;
    r1 = (d1 > r0 + 1) ? d1 : r0 + 1;
    return is8 ? r0 + 2 : r1 + 2;
  endfunction

  function automatic logic [15:0] refValue(input logic is8, input logic [7:0] b0, input logic [7:0] b1);
    int v;
    if (is8) v = (int'(b0) >= 128) ? int'(b0) - 256 : int'(b0);
    else     v = int'(b1) * 256 + int'(b0);
    return 16'(v);
  endfunction

  // Bytes are pushed before start (delay 0) or at the negedge of the given cycle after start.
  task automatic applyStimulus(input logic is8, input logic [7:0] b0, input logic [7:0] b1,
                               input int d0, input int d1, input logic hold,
                               input logic [15:0] exp_imm, input int exp_lat, input int exp_pops);
    int pops0, empties0, comp_cycle, comp_count;
    logic [15:0] got_imm;
    pops0      = pop_count;
    empties0   = empty_reads;
    comp_cycle = -1;
    comp_count = 0;
    got_imm    = 16'hxxxx;
    if (d0 == 0) pushByte(b0);
    if (!is8 && d1 == 0) pushByte(b1);
    is_8bit = is8;
    start   = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("imm_held_during_fetch", immediate, prev_imm);
        checkOutput("busy_in_fetch", busy, 1);
      end
      if (complete) begin
        comp_count++;
        if (comp_cycle < 0) begin
          comp_cycle = c;
          got_imm    = immediate;
        end
      end
      if (d0 == c) pushByte(b0);
      if (!is8 && d1 == c) pushByte(b1);
      if (comp_cycle >= 0 && c == comp_cycle + (hold ? 1 : 0)) start = 1'b0;
      if (comp_cycle >= 0 && c == comp_cycle + 3) checkOutput("busy_after_op", busy, 0);
      if (comp_cycle >= 0 && c >= comp_cycle + 4) break;
    end
    start = 1'b0;
    checkOutput("latency", comp_cycle, exp_lat);
    checkOutput("complete_count", comp_count, 1);
    checkOutput("immediate", got_imm, exp_imm);
    checkOutput("immediate_hold", immediate, exp_imm);
    checkOutput("pop_count", pop_count - pops0, exp_pops);
    checkOutput("reads_while_empty", empty_reads - empties0, 0);
    prev_imm = exp_imm;
  endtask

  initial begin
    logic        r_is8;
    logic [7:0]  r_b0, r_b1;
    int          r_d0, r_d1, pops0;

    vecs[0] = '{1'b1, 8'h80, 8'h00, 0, 0, 1'b0, 16'hFF80, 3, 1};
    vecs[1] = '{1'b0, 8'h34, 8'h12, 0, 0, 1'b0, 16'h1234, 4, 2};
    vecs[2] = '{1'b1, 8'h7F, 8'h00, 0, 0, 1'b0, 16'h007F, 3, 1};
    vecs[3] = '{1'b0, 8'hCD, 8'hAB, 0, 7, 1'b0, 16'hABCD, 9, 2};
    vecs[4] = '{1'b1, 8'h00, 8'h00, 2, 0, 1'b0, 16'h0000, 4, 1};
    vecs[5] = '{1'b0, 8'hFF, 8'h01, 0, 0, 1'b1, 16'h01FF, 4, 2};

    reset = 1'b0; start = 1'b0; is_8bit = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_complete", complete, 0);
    checkOutput("reset_rd_en", fifo_rd_en, 0);
    checkOutput("reset_immediate", immediate, 16'h0000);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      applyStimulus(vecs[i].is8, vecs[i].b0, vecs[i].b1, vecs[i].d0, vecs[i].d1, vecs[i].hold,
                    vecs[i].exp_imm, vecs[i].exp_lat, vecs[i].exp_pops);

    applyStimulus(1'b0, 8'h34, 8'h12, 0, 0, 1'b0, 16'h1234, 4, 2);

    // Abort a 16-bit fetch one cycle after its first read
    pops0 = pop_count;
    pushByte(8'h55); pushByte(8'h66);
    is_8bit = 1'b0; start = 1'b1;
    @(negedge clk);
    checkOutput("clear_first_rd", fifo_rd_en, 1);
    @(negedge clk);
    clear = 1'b1; start = 1'b0;
    #1 checkOutput("clear_forces_rd_low", fifo_rd_en, 0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    checkOutput("clear_busy", busy, 0);
    checkOutput("clear_no_complete", complete, 0);
    checkOutput("clear_imm_kept", immediate, 16'h1234);
    repeat (3) @(negedge clk);
    checkOutput("clear_imm_still", immediate, 16'h1234);
    checkOutput("clear_pops", pop_count - pops0, 1);
    flushFifo();
    @(negedge clk);
    applyStimulus(1'b0, 8'h77, 8'h88, 0, 0, 1'b0, 16'h8877, 4, 2);

    // clear together with start: request must not be taken
    pushByte(8'h11);
    is_8bit = 1'b1; start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    #1 checkOutput("clear_beats_start", busy, 0);
    flushFifo();
    @(negedge clk);

    // Reset in the middle of a fetch with a read outstanding
    pushByte(8'hA5); pushByte(8'h5A);
    is_8bit = 1'b0; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_complete", complete, 0);
    checkOutput("midreset_rd_en", fifo_rd_en, 0);
    checkOutput("midreset_immediate", immediate, 16'h0000);
    reset = 1'b1; start = 1'b0;
    flushFifo();
    @(negedge clk);
    prev_imm = 16'h0000;

    for (int n = 0; n < 20; n++) begin
      r_is8 = 1'($urandom % 2);
      r_b0  = 8'($urandom);
      r_b1  = 8'($urandom);
      r_d0  = ($urandom % 3 == 0) ? int'($urandom_range(1, 4)) : 0;
      if (r_is8) r_d1 = 0;
      else if (r_d0 == 0) r_d1 = ($urandom % 2 == 0) ? 0 : int'($urandom_range(2, 6));
      else r_d1 = r_d0 + int'($urandom_range(0, 4));
      applyStimulus(r_is8, r_b0, r_b1, r_d0, r_d1, 1'($urandom % 2),
                    refValue(r_is8, r_b0, r_b1), refLatency(r_is8, r_d0, r_d1), r_is8 ? 1 : 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
